mode_switch_ctrl: RTL and testbench

- Parametrised successor to the piano top-level mode controller.
- Selects one of NUM_MODES player channels (auto, learn, competition, etc.) and registers that channel's note, LED, song-number and octave onto the shared output path.
- Adds glitch-free mode switching: outputs are muted for a fixed number of cycles on every mode change.
- Owns the play/pause state: it toggles on the rising edge of start and clears on mode change.
- Sits between the per-mode player blocks and the buzzer/LED/7-segment drivers.

---
 rtl/mode_switch_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mode_switch_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_switch_ctrl.sv
// mode_switch_ctrl
// ----------------
// Mode controller for the piano top level. It picks one of NUM_MODES player
// channels and registers that channel's note, LED, song-number and octave
// onto the shared output path that feeds the buzzer, LED and 7-segment
// drivers. It also owns the play/pause state.
//
// Every mode change mutes the outputs for MUTE_CYCLES cycles. This avoids
// glitches on the shared outputs. If the mode changes again while muted,
// the mute window restarts. An invalid mode (>= NUM_MODES) ends in IDLE
// with all outputs silent.
//
// Optional feature (macro MODE_SWITCH_AUTOSTOP_EN):
//   defined     - a song_done pulse in ACTIVE clears play_state.
//   not defined - song_done is ignored.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   mode        in   requested channel index (>= NUM_MODES is invalid)
//   start       in   play/pause request, acts on its rising edge
//   song_done   in   end-of-song pulse from the active player
//   note_in     in   packed per-channel notes, channel k at [k*NOTE_W +: NOTE_W]
//   led_in      in   packed per-channel LED vectors
//   num_in      in   packed per-channel song numbers
//   oct_in      in   packed per-channel octaves
//   note_out    out  registered selected note (0 = rest)
//   led_out     out  registered selected LED vector
//   num_out     out  registered selected song number
//   octave_out  out  registered selected octave (IDLE_OCT when silent)
//   mode_en     out  one-hot enable of the active channel
//   play_state  out  1 = playing, 0 = paused
//   switching   out  high while the mute window is running
module mode_switch_ctrl #(
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = 3,
    parameter int NOTE_W      = 4,
    parameter int LED_W       = 7,
    parameter int NUM_W       = 4,
    parameter int OCT_W       = 2,
    parameter int MUTE_CYCLES = 16,
    parameter logic [OCT_W-1:0] IDLE_OCT = 2'b01
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MODE_W-1:0]           mode,
    input  logic                        start,
    input  logic                        song_done,
    input  logic [NUM_MODES*NOTE_W-1:0] note_in,
    input  logic [NUM_MODES*LED_W-1:0]  led_in,
    input  logic [NUM_MODES*NUM_W-1:0]  num_in,
    input  logic [NUM_MODES*OCT_W-1:0]  oct_in,
    output logic [NOTE_W-1:0]           note_out,
    output logic [LED_W-1:0]            led_out,
    output logic [NUM_W-1:0]            num_out,
    output logic [OCT_W-1:0]            octave_out,
    output logic [NUM_MODES-1:0]        mode_en,
    output logic                        play_state,
    output logic                        switching
);

    localparam int CNT_W = $clog2(MUTE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD     = CNT_W'(MUTE_CYCLES - 1);
    localparam logic [MODE_W-1:0] INVALID_MODE = MODE_W'(NUM_MODES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUTE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [MODE_W-1:0]  cur_mode, cur_mode_n;
    logic [MODE_W-1:0]  target, target_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               play_n;
    logic               start_d;
    logic               start_rise;

    logic [NOTE_W-1:0]    note_sel;
    logic [LED_W-1:0]     led_sel;
    logic [NUM_W-1:0]     num_sel;
    logic [OCT_W-1:0]     oct_sel;
    logic [NUM_MODES-1:0] en_sel;

    assign start_rise = start & ~start_d;

`ifndef MODE_SWITCH_AUTOSTOP_EN
    // song_done only matters when the autostop feature is built in
    logic unused_song_done;
    assign unused_song_done = song_done;
`endif

    // Next-state, mute counter and play/pause decisions
    always_comb begin
        state_n    = state;
        cur_mode_n = cur_mode;
        target_n   = target;
        cnt_n      = cnt;
        play_n     = play_state;
        case (state)
            ST_IDLE, ST_ACTIVE: begin
                if (mode != cur_mode) begin
                    // A mode change beats a start edge on the same cycle
                    target_n = mode;
                    cnt_n    = CNT_LOAD;
                    state_n  = ST_MUTE;
                    play_n   = 1'b0;
                end else if (state == ST_ACTIVE) begin
`ifdef MODE_SWITCH_AUTOSTOP_EN
                    if (song_done) begin
                        play_n = 1'b0;
                    end else if (start_rise) begin
                        play_n = ~play_state;
                    end else begin
                        play_n = play_state;
                    end
`else
                    if (start_rise) begin
                        play_n = ~play_state;
                    end else begin
                        play_n = play_state;
                    end
`endif
                end else begin
                    // Start edges are ignored in IDLE
                    play_n = play_state;
                end
            end
            ST_MUTE: begin
                if (mode != target) begin
                    // The request moved again, so restart the full window
                    target_n = mode;
                    cnt_n    = CNT_LOAD;
                end else if (cnt == CNT_W'(0)) begin
                    cur_mode_n = target;
                    if ({1'b0, target} < (MODE_W + 1)'(NUM_MODES)) begin
                        state_n = ST_ACTIVE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n    = ST_IDLE;
                cur_mode_n = INVALID_MODE;
                target_n   = INVALID_MODE;
                cnt_n      = CNT_W'(0);
                play_n     = 1'b0;
            end
        endcase
    end

    // Channel mux keyed on the mode that will be current after this edge.
    // This lets the entry edge into ACTIVE already load the new channel.
    always_comb begin
        note_sel = {NOTE_W{1'b0}};
        led_sel  = {LED_W{1'b0}};
        num_sel  = {NUM_W{1'b0}};
        oct_sel  = {OCT_W{1'b0}};
        en_sel   = {NUM_MODES{1'b0}};
        for (int k = 0; k < NUM_MODES; k++) begin
            en_sel[k] = (cur_mode_n == MODE_W'(k));
            note_sel  = note_sel | ({NOTE_W{en_sel[k]}} & note_in[k*NOTE_W +: NOTE_W]);
            led_sel   = led_sel  | ({LED_W{en_sel[k]}}  & led_in[k*LED_W +: LED_W]);
            num_sel   = num_sel  | ({NUM_W{en_sel[k]}}  & num_in[k*NUM_W +: NUM_W]);
            oct_sel   = oct_sel  | ({OCT_W{en_sel[k]}}  & oct_in[k*OCT_W +: OCT_W]);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cur_mode   <= INVALID_MODE;
            target     <= INVALID_MODE;
            cnt        <= CNT_W'(0);
            start_d    <= 1'b0;
            play_state <= 1'b0;
        end else begin
            state      <= state_n;
            cur_mode   <= cur_mode_n;
            target     <= target_n;
            cnt        <= cnt_n;
            start_d    <= start;
            play_state <= play_n;
        end
    end

    // Registered output path: the selected channel in ACTIVE, silence otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            note_out   <= {NOTE_W{1'b0}};
            led_out    <= {LED_W{1'b0}};
            num_out    <= {NUM_W{1'b0}};
            octave_out <= IDLE_OCT;
            mode_en    <= {NUM_MODES{1'b0}};
            switching  <= 1'b0;
        end else begin
            switching <= (state_n == ST_MUTE);
            if (state_n == ST_ACTIVE) begin
                note_out   <= note_sel;
                led_out    <= led_sel;
                num_out    <= num_sel;
                octave_out <= oct_sel;
                mode_en    <= en_sel;
            end else begin
                note_out   <= {NOTE_W{1'b0}};
                led_out    <= {LED_W{1'b0}};
                num_out    <= {NUM_W{1'b0}};
                octave_out <= IDLE_OCT;
                mode_en    <= {NUM_MODES{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Bench for mode_switch_ctrl. It runs directed scenarios followed by
// randomized traffic. Every cycle is compared against a timeline model of
// the mode switch: a remaining-mute counter, the pending and active
// channel, and a play flag.
module tb_mode_switch_ctrl;

    localparam int NM = 4;
    localparam int MUTE = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic        start;
    logic        song_done;
    logic [15:0] note_in;
    logic [27:0] led_in;
    logic [15:0] num_in;
    logic [7:0]  oct_in;
    logic [3:0]  note_out;
    logic [6:0]  led_out;
    logic [3:0]  num_out;
    logic [1:0]  octave_out;
    logic [3:0]  mode_en;
    logic        play_state;
    logic        switching;

    int checks = 0;
    int errors = 0;

    // model state
    int m_rem;
    int m_pend;
    int m_cur;
    bit m_play;
    bit m_prev_start;
    logic [3:0] e_note;
    logic [6:0] e_led;
    logic [3:0] e_num;
    logic [1:0] e_oct;
    logic [3:0] e_en;

    mode_switch_ctrl dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .song_done(song_done),
        .note_in(note_in), .led_in(led_in), .num_in(num_in), .oct_in(oct_in),
        .note_out(note_out), .led_out(led_out), .num_out(num_out),
        .octave_out(octave_out), .mode_en(mode_en), .play_state(play_state),
        .switching(switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge
    task automatic model_step();
        bit started;
        if (!reset) begin
            m_rem = 0; m_cur = NM; m_pend = NM; m_play = 0; m_prev_start = 0;
        end else begin
            started = start && !m_prev_start;
            m_prev_start = start;
            if (m_rem > 0) begin
                if (int'(mode) != m_pend) begin
                    m_pend = int'(mode);
                    m_rem = MUTE;
                end else begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_cur = m_pend;
                end
            end else if (int'(mode) != m_cur) begin
                m_pend = int'(mode);
                m_rem = MUTE;
                m_play = 0;
            end else if (m_cur < NM) begin
`ifdef MODE_SWITCH_AUTOSTOP_EN
                if (song_done) m_play = 0;
                else if (started) m_play = !m_play;
`else
                if (started) m_play = !m_play;
`endif
            end
        end
        if (m_rem == 0 && m_cur < NM) begin
            e_note = note_in[m_cur*4 +: 4];
            e_led  = led_in[m_cur*7 +: 7];
            e_num  = num_in[m_cur*4 +: 4];
            e_oct  = oct_in[m_cur*2 +: 2];
            e_en   = 4'b0001 << m_cur;
        end else begin
            e_note = 4'd0; e_led = 7'd0; e_num = 4'd0; e_oct = 2'b01; e_en = 4'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("note_out", 32'(note_out), 32'(e_note));
        check("led_out", 32'(led_out), 32'(e_led));
        check("num_out", 32'(num_out), 32'(e_num));
        check("octave_out", 32'(octave_out), 32'(e_oct));
        check("mode_en", 32'(mode_en), 32'(e_en));
        check("play_state", 32'(play_state), 32'(m_play));
        check("switching", 32'(switching), 32'(m_rem > 0));
    endtask

    task automatic rand_data();
        note_in = 16'($urandom);
        led_in  = 28'($urandom);
        num_in  = 16'($urandom);
        oct_in  = 8'($urandom);
    endtask

    initial begin
        m_rem = 0; m_cur = NM; m_pend = NM; m_play = 0; m_prev_start = 0;
        reset = 1'b0; mode = 3'd1; start = 1'b0; song_done = 1'b0;
        note_in = 16'h4321; led_in = 28'h1234567; num_in = 16'h9876; oct_in = 8'b11_10_00_11;

        // reset with mode 1 held
        tick(); tick();
        check("rst_note", 32'(note_out), 32'd0);
        check("rst_oct", 32'(octave_out), 32'd1);
        check("rst_switching", 32'(switching), 32'd0);

        // release: 16 muted cycles, then channel 1 on cycle 17
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("mute_sw", 32'(switching), 32'd1);
            check("mute_note", 32'(note_out), 32'd0);
        end
        tick();
        check("first_note", 32'(note_out), 32'd2);
        check("first_en", 32'(mode_en), 32'b0010);

        // one-cycle latency of note selection
        note_in[7:4] = 4'd3; tick(); check("lat3", 32'(note_out), 32'd3);
        note_in[7:4] = 4'd5; tick(); check("lat5", 32'(note_out), 32'd5);

        // 1->2 then 2->3 five cycles into the mute window
        mode = 3'd2; tick();
        for (int i = 0; i < 5; i++) tick();
        mode = 3'd3; tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check("restart_note", 32'(note_out), 32'd0);
            check("restart_sw", 32'(switching), 32'd1);
        end
        tick();
        check("restart_en", 32'(mode_en), 32'b1000);

        // held start toggles once, a second pulse toggles back
        start = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("held_start", 32'(play_state), 32'd1);
        start = 1'b0; tick();
        start = 1'b1; tick();
        check("second_pulse", 32'(play_state), 32'd0);
        start = 1'b0; tick();

        // start pulse during MUTE is ignored
        mode = 3'd0; tick(); tick();
        start = 1'b1; tick(); start = 1'b0; tick();
        check("mute_start", 32'(play_state), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        check("mode0_en", 32'(mode_en), 32'b0001);

        // invalid mode ends in IDLE
        mode = 3'd6;
        for (int i = 0; i < 16; i++) tick();
        check("inv_sw", 32'(switching), 32'd1);
        tick();
        check("inv_sw_done", 32'(switching), 32'd0);
        check("inv_en", 32'(mode_en), 32'd0);
        check("inv_oct", 32'(octave_out), 32'd1);

        // autostop behaviour
        mode = 3'd1;
        for (int i = 0; i < 17; i++) tick();
        start = 1'b1; tick(); start = 1'b0; tick();
        check("as_play", 32'(play_state), 32'd1);
        song_done = 1'b1; tick(); song_done = 1'b0;
`ifdef MODE_SWITCH_AUTOSTOP_EN
        check("as_done", 32'(play_state), 32'd0);
`else
        check("as_done", 32'(play_state), 32'd1);
`endif
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            if ($urandom_range(0, 24) == 0) mode = 3'($urandom);
            start = ($urandom_range(0, 3) == 0);
            song_done = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
